load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface: accepts one load/store request at a time from the CPU core and drives the word-organised `ram` port (`address`, `size`, `read_enable`, `write_enable`, `read_data`, `write_data`). Misaligned accesses that cross a word boundary are split into sequential RAM accesses. Loaded data is reassembled and sign- or zero-extended. Sits between the execute stage and `ram`.

## Interface
Parameters: none.

Ports. One clock; reset is asynchronous and active-high.
- `clock` in 1: system clock, posedge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: high only in IDLE. A request is accepted on an edge where `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in `enums_pkg::mem_size_t`: MEM_BYTE / MEM_BYTEU / MEM_HALF / MEM_HALFU / MEM_WORD.
- `req_address` in 32: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `resp_valid` out 1: one-cycle pulse. For loads it means data is valid; for stores it means the store is complete.
- `resp_rdata` out 32: extended load data; 0 for stores.
- `mem_address` out 32, `mem_size` out `mem_size_t`, `mem_read_enable` out 1, `mem_write_enable` out 1, `mem_write_data` out 32: to `ram`.
- `mem_read_data` in 32: from `ram`. Combinational, valid in the same cycle as `mem_address`.

## Operation
- The request (write, size, address, wdata) is latched on acceptance. Let k = address[1:0] and nxt = {address[31:2]+1, 2'b00}. nxt wraps: 0xFFFF_FFFC+4 → 0x0000_0000.
- Split rule:
  - An access crosses a word boundary for HALF/HALFU with k=3, and for WORD with k≠0.
  - Byte accesses never split.
- Loads:
  - ACCESS0 reads the word at the request address and captures it as lo.
  - If the access crosses, ACCESS1 reads nxt and captures it as hi.
  - Assembly: x = ({hi,lo} >> 8k)[31:0].
  - Extension: BYTE sign-extends bit 7; BYTEU zero-extends [7:0]; HALF sign-extends bit 15; HALFU zero-extends [15:0]; WORD passes x unchanged.
  - `mem_size` = MEM_WORD for all reads.
- Stores, per phase (`mem_write_data` is LSB-justified; `ram` shifts it by the address offset):
  - ACCESS0: address = req_address, size = req_size, data = wdata. `ram` writes only the bytes that lie in this word.
  - ACCESS1 (crossing only):
    - Half with k=3: BYTE at nxt, data = wdata>>8.
    - Word with k=1: BYTE at nxt, data = wdata>>24.
    - Word with k=2: HALF at nxt, data = wdata>>16.
    - Word with k=3: HALF at nxt, data = wdata>>8.
  - ACCESS2 (word with k=3 only): BYTE at nxt+2, data = wdata>>24.
- State machine: IDLE → ACCESS0 → {ACCESS1 → {ACCESS2} →} RESP → IDLE.
  - RESP drives `resp_valid`=1 for exactly one cycle.
  - There is no response backpressure.
- Outside ACCESS states:
  - `mem_*_enable` = 0, `mem_address` = 0, `mem_write_data` = 0, `mem_size` = MEM_WORD.
  - Exactly one of the two enables is high in each ACCESS state.

## Timing
- Request accepted at edge N.
- `resp_valid` is high in the cycle following:
  - edge N+1 for non-split accesses;
  - edge N+2 for split loads and split stores with two phases;
  - edge N+3 for word stores with k=3.
- `req_ready` rises in the cycle after RESP. Back-to-back throughput is therefore one request per 3 cycles minimum.
- Load data is registered from `mem_read_data` at the end of each read ACCESS cycle. `resp_rdata` is registered and valid only while `resp_valid`=1, 0 otherwise.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, all `mem_*` outputs as in idle.
- Reset mid-operation (asserted asynchronously in any ACCESS state):
  - Enables drop immediately; any remaining store phases are abandoned.
  - No `resp_valid` is produced.
  - The unit is in IDLE on the first edge after deassertion.
- Inputs are ignored outside IDLE. Changing `req_*` mid-operation has no effect.

## Structure
- `mem_size_t` stays in `enums_pkg`. Add `lsu_state_t` (IDLE, ACCESS0, ACCESS1, ACCESS2, RESP) to `enums_pkg`.
- One sub-module: `load_extend`, combinational. It takes {hi, lo}, k and size, and returns the 32-bit extended result.
- The FSM, request latch and data registers stay in `load_store_unit`.

## Test plan
RAM preloaded with 0x100 = 0x8877_6655, 0x104 = 0xCCBB_AA99.
- LW 0x100 → one read, `resp_rdata` = 0x8877_6655, `resp_valid` in the cycle after edge N+1.
- LB 0x103 → 0xFFFF_FF88; LBU 0x103 → 0x0000_0088; LHU 0x102 → 0x0000_8877.
- LH 0x103 → reads 0x100 then 0x104, result 0xFFFF_9988. LW 0x102 → 0xAA99_8877, response after edge N+2.
- SW 0x103 with data 0x4433_2211 → three write cycles:
  - WORD@0x103 (data 0x4433_2211);
  - HALF@0x104 (data 0x0044_3322);
  - BYTE@0x106 (data 0x0000_0044).
  - Final RAM contents: 0x100 = 0x1177_6655, 0x104 = 0xCC44_3322.
- LW 0xFFFF_FFFE → reads 0xFFFF_FFFC then 0x0000_0000 (address wrap).
- Reset asserted during ACCESS1 of SH 0x103 → `mem_write_enable` drops in the same cycle, no `resp_valid`, `req_ready`=1 after release. Only byte 0x103 has been modified.

Source files
------------

// File: rtl/enums_pkg.sv
// Shared enumerations for the data-memory path: access size and LSU sequencing state.
package enums_pkg;

  typedef enum logic [2:0] {
    MEM_BYTE  = 3'd0,
    MEM_BYTEU = 3'd1,
    MEM_HALF  = 3'd2,
    MEM_HALFU = 3'd3,
    MEM_WORD  = 3'd4
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS0 = 3'd1,
    ACCESS1 = 3'd2,
    ACCESS2 = 3'd3,
    RESP    = 3'd4
  } lsu_state_t;

  function automatic logic is_half_size(input mem_size_t size);
    return (size == MEM_HALF) || (size == MEM_HALFU);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Reassembles a possibly word-crossing load from {hi, lo} and applies sign/zero extension.
module load_extend
  import enums_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  output logic [31:0] result
);

  logic [31:0] x;

  assign x = 32'(data >> {offset, 3'b000});

  always_comb begin
    result = x;
    case (size)
      MEM_BYTE:  result = {{24{x[7]}}, x[7:0]};
      MEM_BYTEU: result = {24'h0, x[7:0]};
      MEM_HALF:  result = {{16{x[15]}}, x[15:0]};
      MEM_HALFU: result = {16'h0, x[15:0]};
      default:   result = x;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator; splits word-crossing accesses into
// sequential RAM phases and returns extended load data with a one-cycle response pulse.
module load_store_unit
  import enums_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  mem_size_t   req_size,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output mem_size_t   mem_size,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state;
  logic        write_q;
  mem_size_t   size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;

  logic [1:0]  k;
  logic [31:0] nxt;
  logic        is_half;
  logic        crosses;
  logic        three_phase;
  logic [31:0] ext_lo;
  logic [31:0] ext_data;

  assign k           = addr_q[1:0];
  assign nxt         = {addr_q[31:2] + 30'd1, 2'b00};
  assign is_half     = is_half_size(size_q);
  assign crosses     = (is_half && (k == 2'd3)) || ((size_q == MEM_WORD) && (k != 2'd0));
  assign three_phase = write_q && (size_q == MEM_WORD) && (k == 2'd3);
  assign req_ready   = (state == IDLE);

  // The final read phase feeds the extender straight from the RAM so the
  // result can be registered on the same edge that enters RESP.
  assign ext_lo = (state == ACCESS0) ? mem_read_data : lo_q;

  load_extend u_load_extend (
    .data   ({mem_read_data, ext_lo}),
    .offset (k),
    .size   (size_q),
    .result (ext_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      size_q     <= MEM_WORD;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            size_q  <= req_size;
            addr_q  <= req_address;
            wdata_q <= req_wdata;
            state   <= ACCESS0;
          end
        end
        ACCESS0: begin
          lo_q <= mem_read_data;
          if (crosses) begin
            state <= ACCESS1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= write_q ? '0 : ext_data;
          end
        end
        ACCESS1: begin
          if (three_phase) begin
            state <= ACCESS2;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= write_q ? '0 : ext_data;
          end
        end
        ACCESS2: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_address      = '0;
    mem_size         = MEM_WORD;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    case (state)
      ACCESS0: begin
        if (write_q) begin
          mem_write_enable = 1'b1;
          mem_address      = addr_q;
          mem_size         = size_q;
          mem_write_data   = wdata_q;
        end else begin
          mem_read_enable = 1'b1;
          mem_address     = {addr_q[31:2], 2'b00};
        end
      end
      ACCESS1: begin
        mem_address = nxt;
        if (write_q) begin
          mem_write_enable = 1'b1;
          // Remaining bytes of the store that spill into the next word.
          if (is_half) begin
            mem_size       = MEM_BYTE;
            mem_write_data = wdata_q >> 8;
          end else begin
            case (k)
              2'd1: begin
                mem_size       = MEM_BYTE;
                mem_write_data = wdata_q >> 24;
              end
              2'd2: begin
                mem_size       = MEM_HALF;
                mem_write_data = wdata_q >> 16;
              end
              default: begin
                mem_size       = MEM_HALF;
                mem_write_data = wdata_q >> 8;
              end
            endcase
          end
        end else begin
          mem_read_enable = 1'b1;
        end
      end
      ACCESS2: begin
        mem_write_enable = 1'b1;
        mem_address      = nxt + 32'd2;
        mem_size         = MEM_BYTE;
        mem_write_data   = wdata_q >> 24;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word RAM, vector table with a response
// scoreboard, and hand-written split-store, address-wrap and mid-access reset sequences.
module tb_load_store_unit;
  import enums_pkg::*;

  typedef struct {
    logic        wr;
    mem_size_t   size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    mem_size_t   size;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  mem_size_t   req_size;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  mem_size_t   mem_size;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int resp_count = 0;

  logic        ram_load;
  logic [31:0] ram [256];
  exp_t        sb [$];
  wr_t         wlog [$];
  logic [31:0] rlog [$];
  exp_t        mon_e;
  vec_t        vecs [18];

  load_store_unit dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .mem_address      (mem_address),
    .mem_size         (mem_size),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Word RAM: store data is LSB-justified and shifted by the byte offset;
  // bytes that fall beyond the addressed word are dropped.
  function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [1:0] k,
                                            input mem_size_t s, input logic [31:0] d);
    logic [7:0]  m;
    logic [31:0] sd;
    logic [31:0] r;
    case (s)
      MEM_BYTE, MEM_BYTEU: m = 8'h01;
      MEM_HALF, MEM_HALFU: m = 8'h03;
      default:             m = 8'h0F;
    endcase
    m  = m << k;
    sd = d << {k, 3'b000};
    r  = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = sd[8*b +: 8];
    return r;
  endfunction

  always_comb mem_read_data = ram[mem_address[9:2]];

  always @(posedge clock) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[64]  <= 32'h8877_6655;
      ram[65]  <= 32'hCCBB_AA99;
      ram[255] <= 32'hDDCC_BBAA;
      ram[0]   <= 32'h3322_1100;
    end else if (mem_write_enable) begin
      ram[mem_address[9:2]] <= ram_merge(ram[mem_address[9:2]], mem_address[1:0], mem_size,
                                         mem_write_data);
    end
  end

  // Monitor: bus rules every cycle, logs RAM traffic, pops the scoreboard on responses.
  always @(negedge clock) begin
    if (req_valid && req_ready) accept_cyc <= cyc + 1;
    if (mem_write_enable) wlog.push_back('{mem_address, mem_size, mem_write_data});
    if (mem_read_enable) rlog.push_back(mem_address);
    if (!mem_read_enable && !mem_write_enable) begin
      check("idle_addr", mem_address, 32'h0);
      check("idle_wdata", mem_write_data, 32'h0);
      check("idle_size", 32'(mem_size), 32'(MEM_WORD));
    end else begin
      check("one_enable", 32'(mem_read_enable & mem_write_enable), 32'h0);
      if (mem_read_enable) check("read_size", 32'(mem_size), 32'(MEM_WORD));
    end
    if (!resp_valid) check("rdata_zero", resp_rdata, 32'h0);
    if (resp_valid) begin
      resp_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=1 expected=0 rdata=%h", resp_rdata);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
        check({mon_e.name, "_lat"}, 32'(cyc - accept_cyc), 32'(mon_e.lat));
      end
    end
  end

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 12 && sb.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    check({nm, "_drained"}, 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  task automatic issue(input logic w, input mem_size_t s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input int lat,
                       input string nm);
    exp_t e;
    check({nm, "_ready"}, 32'(req_ready), 32'h1);
    e.rdata = exp_rd;
    e.lat   = lat;
    e.name  = nm;
    sb.push_back(e);
    req_write   = w;
    req_size    = s;
    req_address = a;
    req_wdata   = d;
    req_valid   = 1'b1;
    @(posedge clock);
    #1;
    // Scramble the request fields; the latched copy must be unaffected.
    req_valid   = 1'b0;
    req_write   = 1'($urandom);
    req_size    = mem_size_t'($urandom_range(0, 4));
    req_address = $urandom;
    req_wdata   = $urandom;
    wait_drain(nm);
  endtask

  initial begin
    int rc;
    reset       = 1'b1;
    ram_load    = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = MEM_WORD;
    req_address = 32'h0;
    req_wdata   = 32'h0;

    vecs[0]  = '{1'b0, MEM_WORD,  32'h100, 32'h0,        32'h8877_6655, 1, "lw_100"};
    vecs[1]  = '{1'b0, MEM_BYTE,  32'h103, 32'h0,        32'hFFFF_FF88, 1, "lb_103"};
    vecs[2]  = '{1'b0, MEM_BYTEU, 32'h103, 32'h0,        32'h0000_0088, 1, "lbu_103"};
    vecs[3]  = '{1'b0, MEM_HALFU, 32'h102, 32'h0,        32'h0000_8877, 1, "lhu_102"};
    vecs[4]  = '{1'b0, MEM_HALF,  32'h103, 32'h0,        32'hFFFF_9988, 2, "lh_103"};
    vecs[5]  = '{1'b0, MEM_WORD,  32'h102, 32'h0,        32'hAA99_8877, 2, "lw_102"};
    vecs[6]  = '{1'b0, MEM_BYTE,  32'h101, 32'h0,        32'h0000_0066, 1, "lb_101"};
    vecs[7]  = '{1'b0, MEM_HALF,  32'h100, 32'h0,        32'h0000_6655, 1, "lh_100"};
    vecs[8]  = '{1'b0, MEM_WORD,  32'h103, 32'h0,        32'hBBAA_9988, 2, "lw_103"};
    vecs[9]  = '{1'b0, MEM_HALFU, 32'h101, 32'h0,        32'h0000_7766, 1, "lhu_101"};
    vecs[10] = '{1'b1, MEM_WORD,  32'h106, 32'hA1B2_C3D4, 32'h0,        2, "sw_106"};
    vecs[11] = '{1'b0, MEM_WORD,  32'h106, 32'h0,        32'hA1B2_C3D4, 2, "lw_106"};
    vecs[12] = '{1'b1, MEM_HALF,  32'h101, 32'h0000_BEEF, 32'h0,        1, "sh_101"};
    vecs[13] = '{1'b0, MEM_WORD,  32'h100, 32'h0,        32'h88BE_EF55, 1, "lw_100b"};
    vecs[14] = '{1'b1, MEM_BYTE,  32'h10B, 32'h0000_005A, 32'h0,        1, "sb_10b"};
    vecs[15] = '{1'b0, MEM_BYTE,  32'h10B, 32'h0,        32'h0000_005A, 1, "lb_10b"};
    vecs[16] = '{1'b0, MEM_HALF,  32'h10A, 32'h0,        32'h0000_5A00, 1, "lh_10a"};
    vecs[17] = '{1'b0, MEM_HALFU, 32'h103, 32'h0,        32'h0000_9988, 2, "lhu_103"};

    repeat (2) @(posedge clock);
    #1;
    ram_load = 1'b1;
    @(posedge clock);
    #1;
    ram_load = 1'b0;
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_enables", 32'({mem_read_enable, mem_write_enable}), 32'h0);
    check("rst_address", mem_address, 32'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    foreach (vecs[i])
      issue(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].lat,
            vecs[i].name);

    ram_load = 1'b1;
    @(posedge clock);
    #1;
    ram_load = 1'b0;

    // Address wrap across the top of memory.
    rlog.delete();
    issue(1'b0, MEM_WORD, 32'hFFFF_FFFE, 32'h0, 32'h1100_DDCC, 2, "lw_wrap");
    check("wrap_reads", 32'(rlog.size()), 32'd2);
    if (rlog.size() == 2) begin
      check("wrap_addr0", rlog[0], 32'hFFFF_FFFC);
      check("wrap_addr1", rlog[1], 32'h0000_0000);
    end

    // Three-phase word store.
    wlog.delete();
    issue(1'b1, MEM_WORD, 32'h103, 32'h4433_2211, 32'h0, 3, "sw_103");
    check("sw3_writes", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      check("sw3_p0_addr", wlog[0].addr, 32'h103);
      check("sw3_p0_size", 32'(wlog[0].size), 32'(MEM_WORD));
      check("sw3_p0_data", wlog[0].data, 32'h4433_2211);
      check("sw3_p1_addr", wlog[1].addr, 32'h104);
      check("sw3_p1_size", 32'(wlog[1].size), 32'(MEM_HALF));
      check("sw3_p1_data", wlog[1].data, 32'h0044_3322);
      check("sw3_p2_addr", wlog[2].addr, 32'h106);
      check("sw3_p2_size", 32'(wlog[2].size), 32'(MEM_BYTE));
      check("sw3_p2_data", wlog[2].data, 32'h0000_0044);
    end
    check("sw3_ram100", ram[64], 32'h1177_6655);
    check("sw3_ram104", ram[65], 32'hCC44_3322);

    // Reset during ACCESS1 of a split half store.
    check("rsth_ready", 32'(req_ready), 32'h1);
    req_write   = 1'b1;
    req_size    = MEM_HALF;
    req_address = 32'h103;
    req_wdata   = 32'h0000_EEDD;
    req_valid   = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    check("rsth_acc1_we", 32'(mem_write_enable), 32'h1);
    check("rsth_acc1_addr", mem_address, 32'h104);
    rc    = resp_count;
    reset = 1'b1;
    #1;
    check("rsth_we_drop", 32'(mem_write_enable), 32'h0);
    check("rsth_re_low", 32'(mem_read_enable), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rsth_ready_after", 32'(req_ready), 32'h1);
    repeat (3) @(posedge clock);
    #1;
    check("rsth_no_resp", 32'(resp_count - rc), 32'h0);
    check("rsth_ram100", ram[64], 32'hDD77_6655);
    check("rsth_ram104", ram[65], 32'hCC44_3322);
    issue(1'b0, MEM_WORD, 32'h104, 32'h0, 32'hCC44_3322, 1, "post_rst_lw104");
    issue(1'b0, MEM_WORD, 32'h100, 32'h0, 32'hDD77_6655, 1, "post_rst_lw100");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
